// File: rtl/ppu_cfg_commit_ctrl_pkg.sv
// Shared state encoding and timing constants for the frame-aligned PPU config commit path.
// Pure declarations; no latency, no flow control.
package ppu_cfg_commit_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_CFG_IDLE   = 2'd0,
        ST_CFG_SETTLE = 2'd1,
        ST_CFG_WAITVS = 2'd2,
        ST_CFG_COMMIT = 2'd3
    } cfg_state_t;

    localparam int          VS_CNT_W           = 20;
    localparam logic [19:0] VS_TIMEOUT_DEFAULT = 20'hFFFFF;
    localparam int          STABLE_CNT_W       = 4;

endpackage

// File: rtl/register_sync.sv
// Multi-bit 2-FF synchroniser with a reset preset; two cycles of latency.
// No flow control: the destination samples every cycle.
module register_sync #(
    parameter int                   reg_width  = 1,
    parameter logic [reg_width-1:0] reg_preset = '0
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [reg_width-1:0] reg_i,
    output logic [reg_width-1:0] reg_o
);

    logic [reg_width-1:0] meta;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta  <= reg_preset;
            reg_o <= reg_preset;
        end else begin
            meta  <= reg_i;
            reg_o <= meta;
        end
    end

endmodule

// File: rtl/ppu_cfg_commit_ctrl.sv
// Applies a CPU config word to the PPU only at a vsync edge (or timeout / no-video bypass), acks by toggle.
// Latency: 3-cycle request sync + STABLE_CYCLES+1 settle + vsync wait + 1; requests during a wait are queued once.
module ppu_cfg_commit_ctrl
    import ppu_cfg_commit_ctrl_pkg::*;
#(
    parameter int                   CFG_WIDTH     = 96,
    parameter logic [CFG_WIDTH-1:0] CFG_RESET     = '0,
    parameter int                   STABLE_CYCLES = 4,
    parameter logic [19:0]          VS_TIMEOUT    = VS_TIMEOUT_DEFAULT
) (
    input  logic                 N64_CLK_i,
    input  logic                 CTRL_nRST,
    input  logic                 PPU_nRST_i,
    input  logic [CFG_WIDTH-1:0] cfg_i,
    input  logic                 cfg_req_tgl_i,
    input  logic                 nVDSYNC_i,
    input  logic                 VD_nVS_i,
    output logic [CFG_WIDTH-1:0] cfg_o,
    output logic                 cfg_ack_tgl_o,
    output logic                 commit_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam logic [STABLE_CNT_W-1:0] STABLE_LAST = STABLE_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [VS_CNT_W-1:0]     VS_LAST     = VS_TIMEOUT - 20'd1;

    cfg_state_t               state;
    logic                     req_sync;
    logic                     req_last;
    logic                     req_new;
    logic                     vs_buf;
    logic                     vs_fall;
    logic                     pending;
    logic [STABLE_CNT_W-1:0]  stable_cnt;
    logic [VS_CNT_W-1:0]      vs_cnt;
    logic [CFG_WIDTH-1:0]     stage;

    register_sync #(
        .reg_width  (1),
        .reg_preset (1'b0)
    ) u_req_sync (
        .clk   (N64_CLK_i),
        .nrst  (CTRL_nRST),
        .reg_i (cfg_req_tgl_i),
        .reg_o (req_sync)
    );

    // Registered edge flag: a toggle that is already high at reset release counts as a fresh request.
    always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            req_last <= 1'b0;
            req_new  <= 1'b0;
        end else begin
            req_last <= req_sync;
            req_new  <= req_sync ^ req_last;
        end
    end

    // vsync is only meaningful during the sync phase of the VD bus.
    always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            vs_buf  <= 1'b1;
            vs_fall <= 1'b0;
        end else if (!nVDSYNC_i) begin
            vs_buf  <= VD_nVS_i;
            vs_fall <= vs_buf & ~VD_nVS_i;
        end else begin
            vs_fall <= 1'b0;
        end
    end

    // Outputs are loaded on the transition into COMMIT so they are valid during the COMMIT cycle.
    always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            state         <= ST_CFG_IDLE;
            stage         <= CFG_RESET;
            stable_cnt    <= '0;
            vs_cnt        <= '0;
            pending       <= 1'b0;
            cfg_o         <= CFG_RESET;
            cfg_ack_tgl_o <= 1'b0;
            commit_o      <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            commit_o <= 1'b0;
            case (state)
                ST_CFG_IDLE: begin
                    if (req_new) begin
                        state      <= ST_CFG_SETTLE;
                        stable_cnt <= '0;
                        stage      <= cfg_i;
                    end
                end
                ST_CFG_SETTLE: begin
                    stage <= cfg_i;
                    if (req_new) begin
                        stable_cnt <= '0;
                    end else if (cfg_i == stage) begin
                        if (stable_cnt == STABLE_LAST) begin
                            state  <= ST_CFG_WAITVS;
                            vs_cnt <= '0;
                        end else begin
                            stable_cnt <= stable_cnt + 4'd1;
                        end
                    end else begin
                        stable_cnt <= '0;
                    end
                end
                ST_CFG_WAITVS: begin
                    vs_cnt <= vs_cnt + 20'd1;
                    if (req_new) begin
                        pending <= 1'b1;
                    end
                    // vsync wins over a coinciding timeout, so the commit is not flagged as forced.
                    if (vs_fall || !PPU_nRST_i) begin
                        state         <= ST_CFG_COMMIT;
                        cfg_o         <= stage;
                        commit_o      <= 1'b1;
                        cfg_ack_tgl_o <= req_last;
                        timeout_o     <= 1'b0;
                    end else if (vs_cnt == VS_LAST) begin
                        state         <= ST_CFG_COMMIT;
                        cfg_o         <= stage;
                        commit_o      <= 1'b1;
                        cfg_ack_tgl_o <= req_last;
                        timeout_o     <= 1'b1;
                    end
                end
                ST_CFG_COMMIT: begin
                    if (pending || req_new) begin
                        state      <= ST_CFG_SETTLE;
                        pending    <= 1'b0;
                        stable_cnt <= '0;
                        stage      <= cfg_i;
                    end else begin
                        state <= ST_CFG_IDLE;
                    end
                end
                default: state <= ST_CFG_IDLE;
            endcase
        end
    end

    assign busy_o = (state != ST_CFG_IDLE);

endmodule

// File: tb/tb_ppu_cfg_commit_ctrl.sv
// Directed bench for ppu_cfg_commit_ctrl: a scoreboard of expected commits checked by a negedge monitor.
module tb_ppu_cfg_commit_ctrl;

    localparam int W = 96;

    typedef struct packed {
        logic [W-1:0] cfg;
        logic         ack;
        logic         to;
    } exp_t;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         ppu_nrst = 1'b1;
    logic [W-1:0] cfg_in = '0;
    logic         req = 1'b0;
    logic         nvdsync = 1'b1;
    logic         vd_nvs = 1'b1;
    logic [W-1:0] cfg_o;
    logic         ack_o;
    logic         commit_o;
    logic         busy_o;
    logic         timeout_o;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           commits = 0;
    logic [W-1:0] prev_cfg = '0;

    always #5 clk = ~clk;

    ppu_cfg_commit_ctrl #(
        .CFG_WIDTH     (W),
        .CFG_RESET     ('0),
        .STABLE_CYCLES (4),
        .VS_TIMEOUT    (20'd1000)
    ) dut (
        .N64_CLK_i     (clk),
        .CTRL_nRST     (nrst),
        .PPU_nRST_i    (ppu_nrst),
        .cfg_i         (cfg_in),
        .cfg_req_tgl_i (req),
        .nVDSYNC_i     (nvdsync),
        .VD_nVS_i      (vd_nvs),
        .cfg_o         (cfg_o),
        .cfg_ack_tgl_o (ack_o),
        .commit_o      (commit_o),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every commit pops one expectation; outside commits cfg_o must hold.
    always @(negedge clk) begin
        if (nrst) begin
            if (commit_o) begin
                commits++;
                chk_int("sb_nonempty", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("commit_cfg", cfg_o, e.cfg);
                    chk_int("commit_ack", int'(ack_o), int'(e.ack));
                    chk_int("commit_timeout", int'(timeout_o), int'(e.to));
                end
            end else begin
                chk("cfg_hold", cfg_o, prev_cfg);
            end
        end
        prev_cfg = cfg_o;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_commit(input int limit, output int n);
        int cnt;
        bit seen;
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < limit) begin
            @(posedge clk);
            #1;
            cnt++;
            if (commit_o) seen = 1'b1;
        end
        n = seen ? cnt : -1;
    endtask

    // Frame start: vsync low during a sync phase, then released so the next frame can fall again.
    task automatic vsync_and_check(input string tag);
        nvdsync = 1'b0;
        vd_nvs  = 1'b0;
        tick(1);
        chk_int({tag, "_no_commit_at_vsfall"}, int'(commit_o), 0);
        vd_nvs = 1'b1;
        tick(1);
        chk_int({tag, "_commit_after_vsfall"}, int'(commit_o), 1);
        nvdsync = 1'b1;
    endtask

    initial begin
        int n;
        #12;
        chk("rst_cfg", cfg_o, '0);
        chk_int("rst_ack", int'(ack_o), 0);
        chk_int("rst_commit", int'(commit_o), 0);
        chk_int("rst_busy", int'(busy_o), 0);
        chk_int("rst_timeout", int'(timeout_o), 0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        tick(3);

        // Basic vsync-aligned commit
        cfg_in = 96'hA5;
        sb.push_back('{cfg: 96'hA5, ack: 1'b1, to: 1'b0});
        req = 1'b1;
        tick(300);
        chk_int("basic_busy_wait", int'(busy_o), 1);
        chk_int("basic_no_early_commit", commits, 0);
        vsync_and_check("basic");
        tick(2);
        chk_int("basic_commits", commits, 1);
        chk_int("basic_idle", int'(busy_o), 0);

        // Unstable word, bypass mode so settle timing is observable
        ppu_nrst = 1'b0;
        sb.push_back('{cfg: 96'h3C, ack: 1'b0, to: 1'b0});
        req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cfg_in = W'(32'h100 + i);
            tick(2);
        end
        chk_int("unstable_no_commit", commits, 1);
        cfg_in = 96'h3C;
        wait_commit(50, n);
        chk_int("unstable_settle_latency", n, 6);
        tick(3);
        chk_int("unstable_commits", commits, 2);

        // No-video bypass latency from the toggle
        cfg_in = 96'hBEEF;
        sb.push_back('{cfg: 96'hBEEF, ack: 1'b1, to: 1'b0});
        req = 1'b1;
        wait_commit(40, n);
        chk_int("bypass_latency", n, 9);
        tick(3);
        chk_int("bypass_idle", int'(busy_o), 0);

        // Timeout without vsync
        ppu_nrst = 1'b1;
        cfg_in = 96'hDEAD;
        sb.push_back('{cfg: 96'hDEAD, ack: 1'b0, to: 1'b1});
        req = 1'b0;
        wait_commit(1500, n);
        chk_int("timeout_latency", n, 1008);
        tick(3);
        chk_int("timeout_sticky", int'(timeout_o), 1);
        chk_int("timeout_idle", int'(busy_o), 0);

        // Back-to-back: second toggle while waiting for vsync
        cfg_in = 96'h11;
        sb.push_back('{cfg: 96'h11, ack: 1'b0, to: 1'b0});
        sb.push_back('{cfg: 96'h77, ack: 1'b0, to: 1'b0});
        req = 1'b1;
        tick(20);
        cfg_in = 96'h77;
        req = 1'b0;
        tick(6);
        chk_int("b2b_busy", int'(busy_o), 1);
        vsync_and_check("b2b_first");
        tick(20);
        chk_int("b2b_one_commit", commits, 5);
        chk_int("b2b_resettle_busy", int'(busy_o), 1);
        vsync_and_check("b2b_second");
        tick(2);
        chk_int("b2b_final_ack", int'(ack_o), 0);
        chk("b2b_final_cfg", cfg_o, 96'h77);
        chk_int("b2b_idle", int'(busy_o), 0);

        // Reset while waiting for vsync
        cfg_in = 96'h55;
        req = 1'b1;
        tick(20);
        chk_int("rstmid_busy", int'(busy_o), 1);
        nrst = 1'b0;
        #1;
        chk("rstmid_cfg", cfg_o, '0);
        chk_int("rstmid_ack", int'(ack_o), 0);
        chk_int("rstmid_busy_clear", int'(busy_o), 0);
        tick(3);
        nrst = 1'b1;
        sb.push_back('{cfg: 96'h55, ack: 1'b1, to: 1'b0});
        tick(20);
        chk_int("rstmid_redetect_busy", int'(busy_o), 1);
        vsync_and_check("rstmid");
        tick(2);
        chk_int("rstmid_final_ack", int'(ack_o), 1);
        chk("rstmid_final_cfg", cfg_o, 96'h55);

        chk_int("total_commits", commits, 7);
        chk_int("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ppu_cfg_commit_ctrl.md
Name: ppu_cfg_commit_ctrl

Overview:
Frame-aligned configuration scheduler in the N64_CLK_i domain, between the CPU configuration outputs (SYS_CLK domain) and the PPU datapath.
- Takes a configuration word plus a toggle request.
- Waits until the word is stable, then applies it to the PPU only at a vertical-sync boundary, so no frame is rendered with a half-updated configuration.
- Returns a toggle acknowledge to the CPU side.
- Includes a timeout and a no-video bypass so updates never stall.

Parameters:
- CFG_WIDTH, 96: width of the configuration word.
- CFG_RESET, all zeros: value of cfg_o after reset.
- STABLE_CYCLES, 4: consecutive equal samples of cfg_i required before arming (range 2..15).
- VS_TIMEOUT, 20'hFFFFF: N64_CLK_i cycles to wait for vsync before a forced commit.

Ports:
- N64_CLK_i, in, 1: block clock.
- CTRL_nRST, in, 1: reset.
- PPU_nRST_i, in, 1: N64 video-reset status; low means no video, so bypass frame alignment.
- cfg_i, in, CFG_WIDTH: configuration word from the SYS_CLK domain; quasi-static, not synchronised.
- cfg_req_tgl_i, in, 1: request toggle from the SYS_CLK domain.
- nVDSYNC_i, in, 1: VD sync-phase strobe (active low).
- VD_nVS_i, in, 1: vsync bit of the VD bus; active low, valid while nVDSYNC_i is low.
- cfg_o, out, CFG_WIDTH: committed configuration to the PPU.
- cfg_ack_tgl_o, out, 1: acknowledge toggle; equals the request toggle after a commit.
- commit_o, out, 1: one-cycle pulse in the commit cycle.
- busy_o, out, 1: high in any state other than IDLE.
- timeout_o, out, 1: sticky flag; the last commit was forced by timeout.

Behaviour:
- Reset (async, active-low), all registers:
  - cfg_o = CFG_RESET; cfg_ack_tgl_o = 0; commit_o = 0; busy_o = 0; timeout_o = 0.
  - State = IDLE; request synchroniser and last-request register = 0; vs_buf = 1; pending = 0.
- Request path: cfg_req_tgl_i passes through a 2-FF synchroniser, then an edge detector (synced != req_last).
  - The edge sets the request one cycle after the synchroniser output changes, i.e. 3 cycles after the input change.
  - After reset, a request toggle that is already 1 is seen as a fresh request, so ack and req re-align.
- Vsync detect: while nVDSYNC_i == 0, vs_buf <= VD_nVS_i. A frame start is vs_buf going 1->0, registered as a one-cycle vs_fall.
- States: IDLE, SETTLE, WAIT_VS, COMMIT (encoding 2 bits).
- IDLE: on a request, go to SETTLE. Clear stable_cnt and load stage <= cfg_i.
- SETTLE, every cycle:
  - stage <= cfg_i.
  - If cfg_i == stage, stable_cnt++; otherwise stable_cnt = 0.
  - When stable_cnt == STABLE_CYCLES-1 and the word compares equal, go to WAIT_VS and clear the timeout counter.
  - A new request in SETTLE restarts the counter and leaves pending = 0.
- WAIT_VS:
  - On vs_fall, go to COMMIT.
  - If PPU_nRST_i == 0, go to COMMIT on the next cycle (bypass); timeout_o is not set.
  - The timeout counter increments each cycle. When it reaches VS_TIMEOUT, go to COMMIT and set timeout_o.
  - A new request in WAIT_VS sets pending = 1; stage is not reloaded.
- COMMIT, a single cycle:
  - cfg_o <= stage; commit_o = 1; cfg_ack_tgl_o <= synced request value.
  - Clear timeout_o unless this commit is itself the timeout commit.
  - If pending, or a request arrives in this cycle: go to SETTLE and clear pending. Otherwise go to IDLE.
- Simultaneous events: vs_fall in the same cycle as the timeout expiry counts as vsync, so timeout_o = 0. A request and vs_fall in the same WAIT_VS cycle: commit the current stage and set pending.
- cfg_o changes only in the COMMIT cycle and never in any other state.
- Worst-case latency from a request edge (after sync) to commit: STABLE_CYCLES + 1 + wait for vsync (bounded by VS_TIMEOUT) + 1.

Decomposition:
- Into n64adv2_config.vh: state localparams ST_CFG_IDLE, ST_CFG_SETTLE, ST_CFG_WAITVS, ST_CFG_COMMIT; the default VS timeout constant.
- Toggle synchroniser: instance of the existing register_sync (reg_width 1, preset 0).
- Vsync detector: stays inline.
- No new sub-module.

Test Plan:
- Basic: PPU_nRST_i = 1; cfg_i = 96'hA5; toggle req 0->1; emit vsync 300 cycles later. Expect commit_o exactly once, 1 cycle after vs_fall; cfg_o = 96'hA5; ack = 1; timeout_o = 0; cfg_o unchanged before that.
- Unstable word: cfg_i changes every 2 cycles for 20 cycles after the request, then holds 96'h3C. Expect WAIT_VS entered only after 4 equal samples; committed value = 96'h3C.
- Timeout: VS_TIMEOUT = 1000, no vsync. Expect commit at counter = 1000 and timeout_o = 1. The next request commits on a real vsync and timeout_o = 0.
- Bypass: PPU_nRST_i = 0, request issued. Expect commit within STABLE_CYCLES + 5 cycles of the toggle, no vsync needed, timeout_o = 0.
- Back-to-back: second toggle (1->0) while in WAIT_VS with cfg_i changed to 96'h77. Expect first commit of the old value on vsync, a second settle, then commit of 96'h77 on the next vsync; final ack = 0.
- Reset mid-operation: assert CTRL_nRST low in WAIT_VS with req = 1. Expect cfg_o = CFG_RESET and ack = 0 immediately. After release, the request is re-detected and committed; ack = 1.
